sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word width in bits (1..64).
REQ-002 Parameter ADDR_WIDTH, default 2, SHALL set the depth as DEPTH = 2**ADDR_WIDTH words (1..10).
REQ-003 Parameter AF_LEVEL, default DEPTH-1, SHALL set the almost_full threshold (1..DEPTH).
REQ-004 Parameter AE_LEVEL, default 1, SHALL set the almost_empty threshold (0..DEPTH-1).
REQ-005 Ports SHALL be as follows; one clock; reset is synchronous and active-high:
  clk  input  1  rising-edge clock
  rst  input  1  synchronous active-high reset
  flush  input  1  synchronous pointer/count clear
  push  input  1  write request
  push_data  input  DATA_WIDTH  write word
  pop  input  1  read request
  pop_data  output  DATA_WIDTH  head word, first-word-fall-through
  full  output  1  count == DEPTH
  empty  output  1  count == 0
  almost_full  output  1  count >= AF_LEVEL
  almost_empty  output  1  count <= AE_LEVEL
  count  output  ADDR_WIDTH+1  stored words, 0..DEPTH
  overflow  output  1  sticky: push rejected
  underflow  output  1  sticky: pop rejected
  clr_err  input  1  clears overflow/underflow

Function
REQ-006 Storage SHALL be DEPTH x DATA_WIDTH registers, written on the clk edge at wptr when a push is accepted; storage is not reset.
REQ-007 pop_data SHALL be combinational mem[rptr] (zero-latency read); its value is don't-care while empty=1.
REQ-008 wptr and rptr SHALL be ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
REQ-009 full, empty, almost_full, almost_empty SHALL be decoded from the count register only (no other state).
REQ-010 Push accepted = push & (~full | pop); pop accepted = pop & ~empty.
REQ-011 push only, not full: write, wptr+1, count+1.
REQ-012 pop only, not empty: rptr+1, count-1.
REQ-013 push & pop, 0 < count < DEPTH: write and read both occur, both pointers +1, count unchanged.
REQ-014 push & pop while empty: push only accepted, count becomes 1; pop rejected.
REQ-015 push & pop while full: both accepted, count stays DEPTH, full stays 1; pop_data in that cycle is the old head, written word lands in freed slot.
REQ-016 Rejected push SHALL leave memory, wptr, count unchanged and set overflow=1 next cycle.
REQ-017 Rejected pop SHALL leave rptr, count unchanged and set underflow=1 next cycle.
REQ-018 overflow/underflow SHALL hold until clr_err or rst; if clr_err coincides with a new rejection, the flag SHALL be 1 (set wins).
REQ-019 flush SHALL, next cycle, set wptr=rptr=0, count=0, discarding push/pop that cycle; flush does not clear overflow/underflow.
REQ-020 count SHALL never exceed DEPTH or go below 0 under any input sequence.

Reset
REQ-021 rst SHALL have priority over flush, clr_err, push, pop.
REQ-022 After rst: wptr=0, rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
REQ-023 rst asserted mid-operation SHALL discard all stored words within one cycle; no push in that cycle is stored.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, AF_LEVEL=3, AE_LEVEL=1)
REQ-024 Fill/drain: push 0x11,0x22,0x33,0x44 -> count 1..4, almost_full at count 3, full at 4; then 4 pops -> pop_data 0x11,0x22,0x33,0x44 in order, empty=1 after last.
REQ-025 Overflow: at full push 0x55 -> count stays 4, overflow=1, later pops return 0x11..0x44 only; clr_err -> overflow=0.
REQ-026 Underflow/empty simultaneous: empty, pop alone -> underflow=1, count 0; then push 0xA5 & pop together -> count 1, pop_data=0xA5.
REQ-027 Full simultaneous: at full (0x11..0x44) push 0x66 & pop -> pop_data 0x11 that cycle, count 4, full=1; next 4 pops -> 0x22,0x33,0x44,0x66 (wrap exercised).
REQ-028 Flush/reset: with count 3, assert flush -> count 0, empty=1, overflow unchanged; refill 2 words, assert rst together with push -> all outputs at REQ-022 values next cycle.
REQ-029 Random: 10k cycles random push/pop/flush against a queue model -> pop_data, count, all flags match every cycle.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with first-word-fall-through read, count-decoded
// status flags and sticky overflow/underflow error flags.
module sync_fifo_param #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2,
   parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 1,
   parameter int AE_LEVEL   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] L_AF    = (ADDR_WIDTH + 1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] L_AE    = (ADDR_WIDTH + 1)'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wptr;
   logic [ADDR_WIDTH-1:0] r_rptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_overflow;
   logic                  r_underflow;

   logic w_full;
   logic w_empty;
   logic w_push_ok;
   logic w_pop_ok;
   logic w_push_rej;
   logic w_pop_rej;
   logic w_active;

   assign w_full     = (r_count == L_DEPTH);
   assign w_empty    = (r_count == '0);
   // A pop frees a slot in the same cycle, so a push at full is still accepted.
   assign w_push_ok  = push & (~w_full | pop);
   assign w_pop_ok   = pop & ~w_empty;
   assign w_push_rej = push & ~w_push_ok;
   assign w_pop_rej  = pop & ~w_pop_ok;
   assign w_active   = ~rst & ~flush;

   always_ff @(posedge clk) begin
      if (w_active && w_push_ok) begin
         r_mem[r_wptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + ADDR_WIDTH'(1);
         end
         if (w_pop_ok) begin
            r_rptr <= r_rptr + ADDR_WIDTH'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + (ADDR_WIDTH + 1)'(1);
            2'b01:   r_count <= r_count - (ADDR_WIDTH + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Error flags: a new rejection beats clr_err; flush neither sets nor clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (!flush && w_push_rej) begin
            r_overflow <= 1'b1;
         end else if (clr_err) begin
            r_overflow <= 1'b0;
         end
         if (!flush && w_pop_rej) begin
            r_underflow <= 1'b1;
         end else if (clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

   assign pop_data     = r_mem[r_rptr];
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= L_AF);
   assign almost_empty = (r_count <= L_AE);
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (8-bit, depth 4, AF=3, AE=1): directed
// scenarios with hand-written expectations, then a randomised run against a queue model.
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       flush = 1'b0;
   logic       push = 1'b0;
   logic [7:0] push_data = '0;
   logic       pop = 1'b0;
   logic [7:0] pop_data;
   logic       full, empty, almost_full, almost_empty;
   logic [2:0] count;
   logic       overflow, underflow;
   logic       clr_err = 1'b0;

   int total = 0;
   int bad   = 0;

   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;

   sync_fifo_param #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(2),
      .AF_LEVEL(3),
      .AE_LEVEL(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .push(push),
      .push_data(push_data),
      .pop(pop),
      .pop_data(pop_data),
      .full(full),
      .empty(empty),
      .almost_full(almost_full),
      .almost_empty(almost_empty),
      .count(count),
      .overflow(overflow),
      .underflow(underflow),
      .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: act=%0h req=%0h", name, act, req);
      end
   endtask

   // Monitor: every accepted pop presented by the DUT must match the next scoreboard entry.
   always @(negedge clk) begin
      if (pop && !empty && !flush && !rst) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: act=%0h req=none", pop_data);
         end else begin
            chk("pop_data", {24'h0, pop_data}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   // One clock with the given inputs; updates the model and checks all outputs after the edge.
   task automatic cyc(input logic p, input logic [7:0] d, input logic q,
                      input logic f, input logic c, input logic r);
      logic m_full, p_ok, q_ok;
      push = p; push_data = d; pop = q; flush = f; clr_err = c; rst = r;
      m_full = (mq.size() == 4);
      p_ok   = p && (!m_full || q);
      q_ok   = q && (mq.size() != 0);
      if (r) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (f) begin
         mq.delete();
         if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
      end else begin
         if (q_ok) begin
            exp_q.push_back(mq[0]);
            void'(mq.pop_front());
         end
         if (p_ok) mq.push_back(d);
         m_ovf = (p && !p_ok) ? 1'b1 : (c ? 1'b0 : m_ovf);
         m_unf = (q && !q_ok) ? 1'b1 : (c ? 1'b0 : m_unf);
      end
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; rst = 1'b0;
      chk("count", 32'(count), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == 4));
      chk("almost_full", 32'(almost_full), 32'(mq.size() >= 3));
      chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 1));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
      if (mq.size() != 0) chk("head", 32'(pop_data), 32'(mq[0]));
   endtask

   task automatic do_push(input logic [7:0] d);
      cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_pop();
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   logic [7:0] vec [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_ae", 32'(almost_empty), 1);
      chk("rst_af", 32'(almost_full), 0);

      // Fill and drain.
      for (int i = 0; i < 4; i++) begin
         do_push(vec[i]);
         chk("fill_count", 32'(count), 32'(i + 1));
         chk("fill_af", 32'(almost_full), 32'(i >= 2));
         chk("fill_full", 32'(full), 32'(i == 3));
      end
      for (int i = 0; i < 4; i++) begin
         chk("drain_head", 32'(pop_data), 32'(vec[i]));
         do_pop();
      end
      chk("drain_empty", 32'(empty), 1);

      // Overflow at full, then clr_err.
      for (int i = 0; i < 4; i++) do_push(vec[i]);
      do_push(8'h55);
      chk("ovf_count", 32'(count), 4);
      chk("ovf_flag", 32'(overflow), 1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("ovf_clr", 32'(overflow), 0);
      for (int i = 0; i < 4; i++) begin
         chk("ovf_head", 32'(pop_data), 32'(vec[i]));
         do_pop();
      end
      chk("ovf_empty", 32'(empty), 1);

      // Underflow, then push+pop while empty.
      do_pop();
      chk("unf_flag", 32'(underflow), 1);
      chk("unf_count", 32'(count), 0);
      cyc(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("ep_count", 32'(count), 1);
      chk("ep_head", 32'(pop_data), 32'h A5);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("unf_clr", 32'(underflow), 0);

      // Push+pop while full; wrap of both pointers.
      for (int i = 0; i < 4; i++) do_push(vec[i]);
      chk("fp_head_before", 32'(pop_data), 32'h11);
      cyc(1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("fp_count", 32'(count), 4);
      chk("fp_full", 32'(full), 1);
      chk("fp_ovf", 32'(overflow), 0);
      for (int i = 0; i < 4; i++) begin
         chk("fp_head", 32'(pop_data), (i == 3) ? 32'h66 : 32'(vec[i + 1]));
         do_pop();
      end

      // Flush keeps overflow; reset with a coincident push clears everything.
      for (int i = 0; i < 4; i++) do_push(vec[i]);
      do_push(8'h77);
      do_pop();
      chk("fl_pre_count", 32'(count), 3);
      cyc(1'b1, 8'h88, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("fl_count", 32'(count), 0);
      chk("fl_empty", 32'(empty), 1);
      chk("fl_ovf", 32'(overflow), 1);
      do_push(8'h01);
      do_push(8'h02);
      chk("fl_head", 32'(pop_data), 32'h01);
      cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rr_count", 32'(count), 0);
      chk("rr_empty", 32'(empty), 1);
      chk("rr_full", 32'(full), 0);
      chk("rr_ae", 32'(almost_empty), 1);
      chk("rr_af", 32'(almost_full), 0);
      chk("rr_ovf", 32'(overflow), 0);
      chk("rr_unf", 32'(underflow), 0);

      // Randomised traffic against the queue model.
      for (int n = 0; n < 10000; n++) begin
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 499) == 0);
      end

      @(negedge clk);
      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
